fb_scanout_dma: RTL and testbench
=================================

FB_SCANOUT_DMA -- requirements
Module: fb_scanout_dma

Interface
REQ-001 SHALL have parameter H_RES, default 320: pixels per line.
REQ-002 SHALL have parameter V_RES, default 240: lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32: pixel FIFO entries; power of two, at least 8.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: run continuous scanout.
REQ-007 SHALL have port fb_base, input, 32: byte address of the back buffer.
REQ-008 SHALL have port swap_req, input, 1: one-cycle buffer-swap request.
REQ-009 SHALL have port swap_ack, output, 1: one-cycle pulse when the swap takes effect.
REQ-010 SHALL have port avm_address, output, 32: SDRAM read byte address.
REQ-011 SHALL have port avm_read, output, 1: read request.
REQ-012 SHALL have port avm_waitrequest, input, 1: slave stall.
REQ-013 SHALL have port avm_readdata, input, 16: RGB565 pixel.
REQ-014 SHALL have port avm_readdatavalid, input, 1: read return strobe.
REQ-015 SHALL have port aso_data, output, 24: RGB888 as {R,G,B} to the VGA pixel path.
REQ-016 SHALL have ports aso_valid (output, 1), aso_ready (input, 1), aso_sop (output, 1) and aso_eop (output, 1): streaming handshake and frame delimiters.
REQ-017 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 State machine SHALL be IDLE, FETCH, DRAIN.
- IDLE->FETCH when enable=1.
- FETCH->DRAIN when H_RES*V_RES reads have been accepted.
- DRAIN->IDLE when pending=0, the FIFO is empty and the last pixel has been popped.
REQ-019 On IDLE->FETCH: if a swap is pending, cur_base SHALL load fb_base, swap_ack SHALL pulse one cycle, and the pending flag SHALL clear; the read index SHALL reset to 0.
REQ-020 Address of pixel i SHALL be cur_base + 2*i, for i = 0..H_RES*V_RES-1, in raster order.
REQ-021 avm_read SHALL assert in FETCH only when fifo_count + pending < FIFO_DEPTH; the FIFO SHALL never overflow.
REQ-022 avm_address and avm_read SHALL hold stable while avm_waitrequest=1; a read is accepted on avm_read & !avm_waitrequest.
REQ-023 Accept SHALL increment pending, and avm_readdatavalid SHALL decrement it; on simultaneous accept and return, pending SHALL be unchanged.
REQ-024 Each avm_readdatavalid with pending>0 SHALL push avm_readdata into the FIFO; returns with pending=0 SHALL be discarded.
REQ-025 aso_valid SHALL equal FIFO non-empty; a pop SHALL occur on aso_valid & aso_ready, with zero-latency show-ahead output.
REQ-026 Colour expansion SHALL be R={r[4:0],r[4:2]}, G={g[5:0],g[5:4]}, B={b[4:0],b[4:2]} (bit replication).
REQ-027 aso_sop SHALL be high on output pixel 0 and aso_eop on output pixel H_RES*V_RES-1; both SHALL be qualified by aso_valid.
REQ-028 enable deasserted mid-frame: the frame SHALL complete, then the block SHALL remain in IDLE.
REQ-029 swap_req at any time SHALL set the pending flag; multiple requests SHALL coalesce; fb_base SHALL be sampled at frame start, not at request time.
REQ-030 FIFO empty while the consumer is ready (underflow) SHALL only drop aso_valid; there SHALL be no error state and no pixel skip.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, all counters 0, FIFO empty, pending 0, cur_base 0, swap flag 0.
REQ-032 During reset, all outputs SHALL be 0, including busy, swap_ack, avm_read, aso_valid, aso_sop, aso_eop and aso_data.
REQ-033 Reset mid-frame SHALL abandon outstanding reads; their late returns SHALL be discarded per REQ-024.

Configuration
REQ-034 Macro FB_SCANOUT_STATS_EN defined SHALL add output underflow_cnt[15:0].
- It SHALL increment each cycle where busy=1, aso_ready=1, aso_valid=0 and the frame is not fully popped.
- It SHALL saturate at 0xFFFF and clear at frame start.
- Without the macro, the port and its logic SHALL be absent.

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=8)
REQ-035 Bench SHALL cover: fb_base=0x1000 with swap, waitrequest=0, 1-cycle return, aso_ready=1 -> addresses 0x1000..0x100E step 2, 8 beats out, sop on beat 0, eop on beat 7, busy falls after beat 7.
REQ-036 Bench SHALL cover: readdata 0xF800/0x07E0/0x001F/0xFFFF -> aso_data 0xFF0000/0x00FF00/0x0000FF/0xFFFFFF.
REQ-037 Bench SHALL cover: aso_ready=0 for 50 cycles -> exactly 8 reads accepted, then avm_read=0; release ready -> remaining 0 reads and 8 beats in order, no loss.
REQ-038 Bench SHALL cover: waitrequest=1 for 5 cycles on pixel 3 -> avm_address=0x1006 and avm_read=1 held stable throughout.
REQ-039 Bench SHALL cover: swap_req with fb_base=0x2000 during frame 1 -> frame 1 stays at 0x1000; swap_ack pulses once at frame 2 start; frame 2 first address is 0x2000.
REQ-040 Bench SHALL cover: reset_n low with 3 reads pending, then 3 late readdatavalid pulses -> all outputs 0; FIFO stays empty; next frame correct. With FB_SCANOUT_STATS_EN, a 10-cycle return delay -> underflow_cnt=10.

Source files
------------

// File: rtl/fb_scanout_dma.sv
// Framebuffer scanout DMA: reads an H_RES x V_RES RGB565 frame over Avalon-MM and streams RGB888 pixels.
// Defining FB_SCANOUT_STATS_EN adds the underflow_cnt output and its counter.
module fb_scanout_dma #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] fb_base,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [15:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [23:0] aso_data,
  output logic        aso_valid,
  input  logic        aso_ready,
  output logic        aso_sop,
  output logic        aso_eop,
  output logic        busy
`ifdef FB_SCANOUT_STATS_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_next;
  logic              start;
  logic [31:0]       cur_base;
  logic              swap_pending;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [15:0]       mem [FIFO_DEPTH];
  logic              room, accept, push, pop;
  logic [15:0]       head;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = FETCH;
          start      = 1'b1;
        end
      end
      FETCH: begin
        if (accept && rd_idx == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        if (pending == '0 && fifo_count == '0 && pop_idx == TOTAL_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Reads in flight plus stored pixels never exceed the FIFO, so returns always fit.
  assign room        = ({1'b0, fifo_count} + {1'b0, pending}) < DEPTH_EXT;
  assign avm_read    = (state == FETCH) && room;
  assign avm_address = cur_base + (32'(rd_idx) << 1);
  assign accept      = avm_read && !avm_waitrequest;
  assign push        = avm_readdatavalid && (pending != '0);
  assign aso_valid   = (fifo_count != '0);
  assign pop         = aso_valid && aso_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      cur_base     <= '0;
    end else begin
      swap_pending <= (swap_pending && !start) || swap_req;
      swap_ack     <= start && swap_pending;
      if (start && swap_pending) cur_base <= fb_base;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx  <= '0;
      pop_idx <= '0;
    end else if (start) begin
      rd_idx  <= '0;
      pop_idx <= '0;
    end else begin
      if (accept) rd_idx  <= rd_idx + 1'b1;
      if (pop)    pop_idx <= pop_idx + 1'b1;
    end
  end

  // Returns that arrive with nothing outstanding belong to an abandoned frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      case ({accept, push})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  assign head     = mem[rd_ptr];
  assign aso_data = aso_valid ? {head[15:11], head[15:13],
                                 head[10:5],  head[10:9],
                                 head[4:0],   head[4:2]} : 24'd0;
  assign aso_sop  = aso_valid && (pop_idx == '0);
  assign aso_eop  = aso_valid && (pop_idx == LAST_IDX);

`ifdef FB_SCANOUT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_cnt <= '0;
    end else if (start) begin
      underflow_cnt <= '0;
    end else if (busy && aso_ready && !aso_valid && pop_idx != TOTAL_IDX &&
                 underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_scanout_dma.sv
// Scoreboard bench for fb_scanout_dma at H_RES=4, V_RES=2, FIFO_DEPTH=8 with a behavioural Avalon slave.
`timescale 1ns/1ps
module tb_fb_scanout_dma;

  localparam int H_RES      = 4;
  localparam int V_RES      = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int TOTAL      = H_RES * V_RES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] fb_base = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [23:0] aso_data;
  logic        aso_valid;
  logic        aso_ready = 1'b1;
  logic        aso_sop;
  logic        aso_eop;
  logic        busy;
`ifdef FB_SCANOUT_STATS_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  fb_scanout_dma #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .fb_base(fb_base),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .aso_data(aso_data),
    .aso_valid(aso_valid),
    .aso_ready(aso_ready),
    .aso_sop(aso_sop),
    .aso_eop(aso_eop),
    .busy(busy)
`ifdef FB_SCANOUT_STATS_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } ret_t;

  ret_t        ret_q[$];
  logic [23:0] sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  int          cyc = 0;
  logic [31:0] exp_base = '0;
  bit          model_swap = 1'b0;
  int          frame_acc = 0;
  int          beat_idx = 0;
  int          acc_total = 0;
  int          beat_total = 0;
  int          ack_total = 0;
  int          exp_ack_total = 0;
  int          ret_total = 0;
  bit          color_mode = 1'b0;
  int          ret_lat = 1;
  int          accept_limit = 0;
  int          stall_idx = 0;
  int          stall_len = 0;
  int          stall_done = 0;
  int          hold_busy = 0;

  logic [15:0] color_in  [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
  logic [23:0] color_out [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] pixelWord(input logic [31:0] addr);
    logic [15:0] a;
    a = addr[16:1];
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [23:0] expand565(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {p[15:11], p[15:13]};
    g = {p[10:5], p[10:9]};
    b = {p[4:0], p[4:2]};
    return {r, g, b};
  endfunction

  // Slave and stream monitor share one process so accepts and beats are ordered within a cycle.
  initial begin : bus_model
    ret_t        r;
    logic        wr;
    logic [15:0] word;
    logic [23:0] expv;
    forever begin
      @(negedge clk);
      cyc++;
      if (swap_ack) begin
        ack_total++;
        checkOutput("ack_addr", avm_address, fb_base);
      end
      if (aso_valid) begin
        checkOutput("sop", 32'(aso_sop), 32'(beat_idx == 0));
        checkOutput("eop", 32'(aso_eop), 32'(beat_idx == TOTAL - 1));
        if (aso_ready) begin
          checkOutput("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            expv = sb_q.pop_front();
            checkOutput("pixel", 32'(aso_data), 32'(expv));
          end
          beat_idx = (beat_idx + 1) % TOTAL;
          beat_total++;
        end
      end else begin
        checkOutput("sop_idle", 32'(aso_sop), 32'd0);
        checkOutput("eop_idle", 32'(aso_eop), 32'd0);
      end

      if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = r.data;
        ret_total++;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end

      wr = 1'b0;
      if (hold_busy > 0 && busy) begin
        wr = 1'b1;
        hold_busy--;
      end else if (accept_limit > 0 && frame_acc >= accept_limit) begin
        wr = 1'b1;
      end else if (stall_len > 0 && frame_acc == stall_idx && stall_done < stall_len &&
                   (avm_read || stall_done > 0)) begin
        wr = 1'b1;
        stall_done++;
        checkOutput("stall_read", 32'(avm_read), 32'd1);
        checkOutput("stall_addr", avm_address, exp_base + 32'(2 * stall_idx));
      end
      avm_waitrequest = wr;

      if (avm_read && !wr) begin
        if (frame_acc == 0 && model_swap) begin
          exp_base   = fb_base;
          model_swap = 1'b0;
          exp_ack_total++;
        end
        checkOutput("rd_addr", avm_address, exp_base + 32'(2 * frame_acc));
        word = color_mode ? color_in[frame_acc % 4] : pixelWord(avm_address);
        expv = color_mode ? color_out[frame_acc % 4] : expand565(word);
        sb_q.push_back(expv);
        r.data = word;
        r.due  = cyc + ret_lat;
        ret_q.push_back(r);
        frame_acc = (frame_acc + 1) % TOTAL;
        acc_total++;
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Optionally request a swap, then pulse enable for a single frame.
  task automatic applyStimulus(input bit do_swap, input logic [31:0] base);
    if (do_swap) begin
      fb_base    = base;
      swap_req   = 1'b1;
      model_swap = 1'b1;
      stepCycles(1);
      swap_req = 1'b0;
    end
    enable = 1'b1;
    stepCycles(1);
    enable = 1'b0;
  endtask

  task automatic waitFrame(input int target);
    int n;
    n = 0;
    while (!(beat_total >= target && !busy) && n < 500) begin
      stepCycles(1);
      n++;
    end
    checkOutput("frame_done", 32'(beat_total >= target && !busy), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ack"}, 32'(swap_ack), 32'd0);
    checkOutput({tag, "_read"}, 32'(avm_read), 32'd0);
    checkOutput({tag, "_addr"}, avm_address, 32'd0);
    checkOutput({tag, "_valid"}, 32'(aso_valid), 32'd0);
    checkOutput({tag, "_sop"}, 32'(aso_sop), 32'd0);
    checkOutput({tag, "_eop"}, 32'(aso_eop), 32'd0);
    checkOutput({tag, "_data"}, 32'(aso_data), 32'd0);
`ifdef FB_SCANOUT_STATS_EN
    checkOutput({tag, "_ufl"}, 32'(underflow_cnt), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int a0, b0, ack0, r0, n;

    enable   = 1'b1;
    swap_req = 1'b1;
    fb_base  = 32'hDEAD_BEE0;
    stepCycles(3);
    checkResetOutputs("reset");
    enable   = 1'b0;
    swap_req = 1'b0;
    fb_base  = '0;
    stepCycles(1);
    reset_n = 1'b1;
    stepCycles(2);

    $display("[TB] frame with swap to 0x1000 and primary colours");
    color_mode = 1'b1;
    a0 = acc_total;
    b0 = beat_total;
    applyStimulus(1'b1, 32'h1000);
    waitFrame(b0 + TOTAL);
    checkOutput("colour_accepts", 32'(acc_total - a0), 32'(TOTAL));
    checkOutput("colour_beats", 32'(beat_total - b0), 32'(TOTAL));
    checkOutput("colour_ack", 32'(ack_total), 32'd1);
    stepCycles(10);
    checkOutput("stays_idle", 32'(busy), 32'd0);
    color_mode = 1'b0;

    $display("[TB] consumer stalled for 50 cycles");
    aso_ready = 1'b0;
    a0 = acc_total;
    b0 = beat_total;
    applyStimulus(1'b0, '0);
    stepCycles(50);
    checkOutput("stalled_accepts", 32'(acc_total - a0), 32'(TOTAL));
    checkOutput("stalled_read", 32'(avm_read), 32'd0);
    checkOutput("stalled_valid", 32'(aso_valid), 32'd1);
    checkOutput("stalled_beats", 32'(beat_total - b0), 32'd0);
    aso_ready = 1'b1;
    waitFrame(b0 + TOTAL);
    checkOutput("release_accepts", 32'(acc_total - a0), 32'(TOTAL));
    checkOutput("release_beats", 32'(beat_total - b0), 32'(TOTAL));

    $display("[TB] waitrequest held for 5 cycles on pixel 3");
    stall_idx  = 3;
    stall_len  = 5;
    stall_done = 0;
    b0 = beat_total;
    applyStimulus(1'b0, '0);
    waitFrame(b0 + TOTAL);
    checkOutput("stall_cycles", 32'(stall_done), 32'd5);
    stall_len = 0;

    $display("[TB] swap requested mid-frame, two frames back to back");
    ack0 = ack_total;
    b0 = beat_total;
    enable = 1'b1;
    stepCycles(4);
    fb_base    = 32'h2000;
    swap_req   = 1'b1;
    model_swap = 1'b1;
    stepCycles(1);
    swap_req = 1'b0;
    stepCycles(2);
    swap_req = 1'b1;
    stepCycles(1);
    swap_req = 1'b0;
    n = 0;
    while (beat_total < b0 + TOTAL && n < 500) begin
      stepCycles(1);
      n++;
    end
    checkOutput("frame1_done", 32'(beat_total >= b0 + TOTAL), 32'd1);
    checkOutput("no_early_ack", 32'(ack_total - ack0), 32'd0);
    stepCycles(5);
    enable = 1'b0;
    waitFrame(b0 + 2 * TOTAL);
    checkOutput("swap_ack_once", 32'(ack_total - ack0), 32'd1);
    checkOutput("ack_vs_model", 32'(ack_total), 32'(exp_ack_total));
    stepCycles(10);
    checkOutput("idle_after_swap", 32'(busy), 32'd0);

`ifdef FB_SCANOUT_STATS_EN
    $display("[TB] first pixel delayed 10 cycles, underflow counter");
    hold_busy = 8;
    b0 = beat_total;
    applyStimulus(1'b0, '0);
    waitFrame(b0 + TOTAL);
    checkOutput("underflow_cnt", 32'(underflow_cnt), 32'd10);
    checkOutput("hold_consumed", 32'(hold_busy), 32'd0);
`endif

    $display("[TB] reset with 3 reads outstanding");
    ret_lat      = 30;
    accept_limit = 3;
    a0 = acc_total;
    applyStimulus(1'b0, '0);
    stepCycles(8);
    checkOutput("pre_reset_accepts", 32'(acc_total - a0), 32'd3);
    r0 = ret_total;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    sb_q.delete();
    frame_acc    = 0;
    beat_idx     = 0;
    exp_base     = '0;
    model_swap   = 1'b0;
    accept_limit = 0;
    stepCycles(3);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      stepCycles(1);
      checkOutput("late_valid", 32'(aso_valid), 32'd0);
      checkOutput("late_busy", 32'(busy), 32'd0);
    end
    checkOutput("late_returns", 32'(ret_total - r0), 32'd3);
    ret_lat = 1;

    $display("[TB] frame after reset");
    a0 = acc_total;
    b0 = beat_total;
    applyStimulus(1'b0, '0);
    waitFrame(b0 + TOTAL);
    checkOutput("post_reset_accepts", 32'(acc_total - a0), 32'(TOTAL));
    checkOutput("post_reset_beats", 32'(beat_total - b0), 32'(TOTAL));
    checkOutput("final_ack", 32'(ack_total), 32'(exp_ack_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
